// File: rtl/custom_subtractor41_20_seq_pkg.sv
// Shared constants, slice geometry and FSM state type for the sliced
// 41-bit minus 21-bit sequential subtractor.
package subtractor_pkg;

    localparam int A_W    = 41;
    localparam int B_W    = 21;
    localparam int CHUNK  = 8;
    localparam int DIFF_W = A_W + 1;

    function automatic int ceilDiv(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    localparam int NSLICE   = ceilDiv(A_W, CHUNK);
    localparam int PAD_W    = NSLICE * CHUNK;
    localparam int SLICE_CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/custom_subtractor41_20_seq_sub_chunk.sv
// Combinational W-bit slice subtractor: {bout, diff} = a - b - bin.
module sub_chunk
    import subtractor_pkg::*;
#(
    parameter int W = CHUNK
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic [W-1:0] diff_o,
    output logic         bout_o
);

    // One extra bit on top turns negative results into a set borrow-out.
    assign {bout_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};

endmodule

// File: rtl/custom_subtractor41_20_seq.sv
// Multi-cycle A - zero_extend(B) subtractor: one CHUNK-bit slice per cycle
// with a registered rippled borrow, behind valid/ready handshakes.
module custom_subtractor41_20_seq
    import subtractor_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [A_W-1:0]    a_i,
    input  logic [B_W-1:0]    b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DIFF_W-1:0] diff_o,
    output logic              busy_o
);

    state_t                state_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic [A_W-1:0]        a_q;
    logic [B_W-1:0]        b_q;
    logic [DIFF_W-1:0]     diff_q;
    logic [SLICE_CW-1:0]   slice_q;
    logic                  borrow_q;

    logic [PAD_W-1:0]      aPad;
    logic [PAD_W-1:0]      bPad;
    logic [CHUNK-1:0]      aSlices [NSLICE];
    logic [CHUNK-1:0]      bSlices [NSLICE];
    logic [CHUNK-1:0]      sliceA;
    logic [CHUNK-1:0]      sliceB;
    logic [CHUNK-1:0]      sliceDiff;
    logic                  sliceBout;
    logic                  lastSlice;
    logic [A_W-1:0]        diffLow_d;

    // Zero padding keeps the partial top slice and the unused B bits X-free.
    assign aPad = {{(PAD_W - A_W){1'b0}}, a_q};
    assign bPad = {{(PAD_W - B_W){1'b0}}, b_q};

    assign lastSlice = (slice_q == SLICE_CW'(NSLICE - 1));

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        localparam int LO = k * CHUNK;
        localparam int SW = ((A_W - LO) < CHUNK) ? (A_W - LO) : CHUNK;

        assign aSlices[k] = aPad[LO +: CHUNK];
        assign bSlices[k] = bPad[LO +: CHUNK];
        assign diffLow_d[LO +: SW] = (slice_q == SLICE_CW'(k)) ? sliceDiff[SW-1:0]
                                                                : diff_q[LO +: SW];
    end

    assign sliceA = aSlices[slice_q];
    assign sliceB = bSlices[slice_q];

    sub_chunk #(
        .W (CHUNK)
    ) u_sub_chunk (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .bin_i  (borrow_q),
        .diff_o (sliceDiff),
        .bout_o (sliceBout)
    );

    // Control FSM and datapath registers; the last slice's borrow-out
    // becomes the sign bit of the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            slice_q     <= '0;
            borrow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        borrow_q   <= 1'b0;
                        slice_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    diff_q[A_W-1:0] <= diffLow_d;
                    borrow_q        <= sliceBout;
                    if (lastSlice) begin
                        diff_q[A_W] <= sliceBout;
                        slice_q     <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        slice_q <= slice_q + SLICE_CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign diff_o      = diff_q;

endmodule
